line_window_gen: RTL

Streaming 3x3 window generator between the AXI4-Stream pixel input of `imageFilterTop` and its convolution core. It accepts 8-bit pixels in raster order, buffers the two previous lines, and emits one 3x3 neighbourhood per accepted pixel once two full lines are stored. Output framing matches the output stream: EOL on the last column, EOF on the last pixel of the frame. The window is packed so kernel weight W1..W9 maps directly to window index 0..8.

---
 rtl/img_filter_pkg.sv | 12 +
 rtl/line_window_gen_if.sv | 29 ++
 rtl/line_buffer.sv | 25 ++
 rtl/line_window_gen.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/img_filter_pkg.sv
// Shared constants and helpers for the image filter pipeline.
// The window index helper maps (row, column) to kernel weight slot W1..W9.
package img_filter_pkg;

  localparam int unsigned PixelWidth = 8;
  localparam int unsigned WinSize    = 3;

  function automatic int unsigned win_idx(input int unsigned i, input int unsigned j);
    return WinSize * i + j;
  endfunction

endpackage

// File: rtl/line_window_gen_if.sv
// Valid/ready stream bundle used for both the pixel input and the window output.
// On the window stream, tuser carries end-of-line and tlast carries end-of-frame.
interface line_window_gen_if #(
  parameter int unsigned DataWidth = 8
) ();

  logic                 tvalid;
  logic                 tready;
  logic [DataWidth-1:0] tdata;
  logic                 tuser;
  logic                 tlast;

  modport master (
    output tvalid,
    output tdata,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tuser,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/line_buffer.sv
// Single-port line store with asynchronous read, so the old contents at an
// address are visible in the same cycle that the address is overwritten.
module line_buffer #(
  parameter int unsigned Depth     = 512,
  parameter int unsigned Width     = 8,
  parameter int unsigned AddrWidth = 9
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [Width-1:0]     wdata_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/line_window_gen.sv
// Streaming 3x3 window generator: buffers two previous lines and emits one
// neighbourhood per accepted pixel from the third line of the frame onward.
module line_window_gen
  import img_filter_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH        = PixelWidth,
  parameter int unsigned IMAGE_WIDTH_SIZE       = 512,
  parameter int unsigned IMAGE_WIDTH_LOG2_SIZE  = 9,
  parameter int unsigned IMAGE_HEIGHT_SIZE      = 512,
  parameter int unsigned IMAGE_HEIGHT_LOG2_SIZE = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  line_window_gen_if.slave          s_axis,
  line_window_gen_if.master         m_win,
  output logic                      frame_err
);

  localparam int unsigned W  = AXIS_DATA_WIDTH;
  localparam int unsigned CW = IMAGE_WIDTH_LOG2_SIZE;
  localparam int unsigned RW = IMAGE_HEIGHT_LOG2_SIZE;

  localparam logic [CW-1:0] ColOne  = CW'(1);
  localparam logic [CW-1:0] ColLast = CW'(IMAGE_WIDTH_SIZE - 1);
  localparam logic [RW-1:0] RowOne  = RW'(1);
  localparam logic [RW-1:0] RowTwo  = RW'(2);
  localparam logic [RW-1:0] RowLast = RW'(IMAGE_HEIGHT_SIZE - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;

  // win_q[i][j]: row i (0 = oldest line), column j (0 = oldest column).
  logic [WinSize-1:0][WinSize-1:0][W-1:0] win_q, win_d;

  logic [W-1:0] lb0_rd, lb1_rd;
  logic         accept;
  logic         col_last, row_last;

  assign s_axis.tready = enable && (!valid_q || m_win.tready);
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign col_last      = (col_q == ColLast);
  assign row_last      = (row_q == RowLast);

  line_buffer #(
    .Depth     (IMAGE_WIDTH_SIZE),
    .Width     (W),
    .AddrWidth (CW)
  ) u_lb0 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (s_axis.tdata),
    .rdata_o (lb0_rd)
  );

  line_buffer #(
    .Depth     (IMAGE_WIDTH_SIZE),
    .Width     (W),
    .AddrWidth (CW)
  ) u_lb1 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  // Position tracking and framing checks; tlast outranks tuser.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    err_d = err_q;
    if (accept) begin
      if (s_axis.tlast) begin
        col_d = '0;
        row_d = '0;
        if (!(row_last && col_last)) begin
          err_d = 1'b1;
        end
      end else if (s_axis.tuser || col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RowOne;
        if (!(s_axis.tuser && col_last)) begin
          err_d = 1'b1;
        end
      end else begin
        col_d = col_q + ColOne;
      end
    end
  end

  // Shift in the new column; left-edge columns are zero-filled.
  always_comb begin
    win_d   = win_q;
    valid_d = valid_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    if (accept) begin
      for (int i = 0; i < int'(WinSize); i++) begin
        win_d[i][0] = ((col_q == '0) || (col_q == ColOne)) ? '0 : win_q[i][1];
        win_d[i][1] = (col_q == '0) ? '0 : win_q[i][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = s_axis.tdata;
      valid_d     = (row_q >= RowTwo);
      eol_d       = col_last;
      eof_d       = col_last && row_last;
    end else if (m_win.tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      win_q   <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      win_q   <= win_d;
    end
  end

  for (genvar i = 0; i < int'(WinSize); i++) begin : g_row
    for (genvar j = 0; j < int'(WinSize); j++) begin : g_col
      assign m_win.tdata[W*win_idx(i, j) +: W] = win_q[i][j];
    end
  end

  assign m_win.tvalid = valid_q;
  assign m_win.tuser  = eol_q;
  assign m_win.tlast  = eof_q;
  assign frame_err    = err_q;

endmodule
